param_divider: RTL
==================

PARAM_DIVIDER -- requirements
Module: param_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits; legal values are 2..64.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port Rst, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-004 Port Run, input, 1 bit, SHALL be the start request, sampled each rising edge.
REQ-005 Port Sgn, input, 1 bit, SHALL select the operation mode: 1 = two's-complement signed, 0 = unsigned; sampled with Run.
REQ-006 Port Dvnd, input, WIDTH bits, SHALL carry the dividend; sampled with Run.
REQ-007 Port Dvsr, input, WIDTH bits, SHALL carry the divisor; sampled with Run.
REQ-008 Port Q, output, WIDTH bits, SHALL present the registered quotient.
REQ-009 Port R, output, WIDTH bits, SHALL present the registered remainder.
REQ-010 Port Rdy, output, 1 bit, SHALL indicate that Q, R and DivZ are valid.
REQ-011 Port Busy, output, 1 bit, SHALL indicate that a division is in progress.
REQ-012 Port DivZ, output, 1 bit, SHALL flag that the last accepted operation had Dvsr == 0.

Function
REQ-013 The FSM SHALL have three states: IDLE, DIV and DONE.
REQ-014 In IDLE or DONE, Run=1 at an edge SHALL capture Sgn, Dvnd and Dvsr, clear Rdy and DivZ, and enter DIV (or DONE for divide-by-zero, see REQ-020).
REQ-015 While in DIV, Run SHALL be ignored, and input changes SHALL NOT affect the result.
REQ-016 Signed capture: operands SHALL be converted to magnitudes; quotient sign = Dvnd[MSB] xor Dvsr[MSB]; remainder sign = Dvnd[MSB] (truncating division).
REQ-017 DIV SHALL perform restoring shift-subtract with a 2*WIDTH-bit remainder/quotient register and a WIDTH+1-bit subtractor, producing one quotient bit per cycle.
REQ-018 An iteration counter SHALL run exactly WIDTH iterations; the last iteration SHALL apply the sign correction and enter DONE.
REQ-019 Latency: Run accepted at edge k SHALL give Rdy=1 with valid Q/R from edge k+WIDTH+1 (33 cycles at WIDTH=32).
REQ-020 Divide-by-zero (Dvsr == 0 at capture, either mode) SHALL skip DIV and enter DONE at edge k+1 with Q = all ones, R = Dvnd, DivZ = 1.
REQ-021 Signed overflow (Dvnd = 2^(WIDTH-1) negative, Dvsr = all ones) SHALL yield Q = Dvnd and R = 0, with DivZ = 0.
REQ-022 Busy SHALL be 1 exactly while in DIV; Rdy SHALL be 1 exactly while in DONE; Busy and Rdy SHALL never both be 1.
REQ-023 In DONE, Q, R and DivZ SHALL hold until the next accepted Run or Rst.
REQ-024 Run held high in DONE SHALL start a new operation every completion (back-to-back), with Rdy low for the DIV cycles.
REQ-025 Rdy SHALL NOT depend on Run being deasserted before the next operation starts.

Reset
REQ-026 Rst=1 at an edge SHALL force IDLE, Q=0, R=0, Rdy=0, Busy=0, DivZ=0, and counter=0.
REQ-027 Rst SHALL override Run when both are high at the same edge.
REQ-028 Rst during DIV SHALL abort the operation with no partial result visible.
REQ-029 After Rst deasserts, the block SHALL accept Run on the first following edge.

Verification
REQ-030 Unsigned, WIDTH=32, Sgn=0, Dvnd=100, Dvsr=7, Run pulse -> Busy for 32 cycles, then Rdy=1 at edge k+33 with Q=14, R=2, DivZ=0.
REQ-031 Signed negative dividend, Sgn=1, Dvnd=0xFFFFFFF9 (-7), Dvsr=2 -> Q=0xFFFFFFFD (-3), R=0xFFFFFFFF (-1).
REQ-032 Signed negative divisor, Sgn=1, Dvnd=7, Dvsr=0xFFFFFFFE (-2) -> Q=0xFFFFFFFD, R=1.
REQ-033 Divide-by-zero, Dvnd=5, Dvsr=0, either Sgn -> Rdy=1 at edge k+1 with Q=0xFFFFFFFF, R=5, DivZ=1, Busy never high.
REQ-034 Signed overflow, Sgn=1, Dvnd=0x80000000, Dvsr=0xFFFFFFFF -> Q=0x80000000, R=0; unsigned 0xFFFFFFFF/1 -> Q=0xFFFFFFFF, R=0.
REQ-035 Abort and busy-ignore: Rst at cycle 10 of DIV -> all outputs 0 next edge; Run re-pulsed during DIV with new operands -> ignored, original result delivered; repeat REQ-030 at WIDTH=8 (Dvnd=200, Dvsr=9) -> Q=22, R=2 at edge k+9.

Source files
------------

// File: rtl/param_divider.sv
// Iterative restoring divider, signed or unsigned.
// One quotient bit per cycle; divide-by-zero finishes at once.
module param_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             Run,
  input  logic             Sgn,
  input  logic [WIDTH-1:0] Dvnd,
  input  logic [WIDTH-1:0] Dvsr,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             Rdy,
  output logic             Busy,
  output logic             DivZ
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] rq_q, rq_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic               divz_q, divz_d;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] rq_next;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;

  // Next-state, capture and one shift-subtract step per DIV cycle
  always_comb begin
    state_d = state_q;
    rq_d    = rq_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    q_d     = q_q;
    r_d     = r_q;
    divz_d  = divz_q;

    mag_a = (Sgn && Dvnd[WIDTH-1]) ? -Dvnd : Dvnd;
    mag_b = (Sgn && Dvsr[WIDTH-1]) ? -Dvsr : Dvsr;

    // Partial remainder shifted left with the next dividend bit
    diff = rq_q[2*WIDTH-1:WIDTH-1] - {1'b0, dvsr_q};
    if (diff[WIDTH]) begin
      rq_next = {rq_q[2*WIDTH-2:0], 1'b0};
    end else begin
      rq_next = {diff[WIDTH-1:0], rq_q[WIDTH-2:0], 1'b1};
    end
    q_mag = rq_next[WIDTH-1:0];
    r_mag = rq_next[2*WIDTH-1:WIDTH];

    unique case (state_q)
      IDLE, DONE: begin
        if (Run) begin
          divz_d = 1'b0;
          if (Dvsr == '0) begin
            state_d = DONE;
            q_d     = '1;
            r_d     = Dvnd;
            divz_d  = 1'b1;
          end else begin
            state_d = DIV;
            rq_d    = {{WIDTH{1'b0}}, mag_a};
            dvsr_d  = mag_b;
            cnt_d   = '0;
            negq_d  = Sgn && (Dvnd[WIDTH-1] ^ Dvsr[WIDTH-1]);
            negr_d  = Sgn && Dvnd[WIDTH-1];
          end
        end
      end
      DIV: begin
        rq_d  = rq_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = DONE;
          cnt_d   = '0;
          q_d     = negq_q ? -q_mag : q_mag;
          r_d     = negr_q ? -r_mag : r_mag;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q <= IDLE;
      rq_q    <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rq_q    <= rq_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      q_q     <= q_d;
      r_q     <= r_d;
      divz_q  <= divz_d;
    end
  end

  assign Q    = q_q;
  assign R    = r_q;
  assign DivZ = divz_q;
  assign Busy = (state_q == DIV);
  assign Rdy  = (state_q == DONE);

endmodule
